// File: rtl/color_blob_tracker.sv
// color_blob_tracker: classifies RGB444 pixels against a target colour window
// and publishes per-frame statistics (count, bounding box, centre) of matches.
//
// Ports:
//   pixel_clock              in   pixel clock (only clock)
//   rst_i                    in   synchronous reset, active-high
//   frame_start, frame_end   in   one-cycle frame delimiters
//   pix_valid, pix_x, pix_y  in   pixel qualifier and coordinates
//   pix_data                 in   {R[11:8], G[7:4], B[3:0]}
//   match_o, match_valid_o   out  per-pixel match / qualify flags, 1-cycle latency
//   result_valid             out  one-cycle pulse when the result set updates
//   found, pix_count         out  frame verdict and matching pixel count
//   x_min..y_max             out  bounding box of matches (0 when not found)
//   x_center, y_center       out  box centre per axis (0 when not found)
module color_blob_tracker #(
  parameter logic [3:0]  R_MIN     = 4'd10,
  parameter logic [3:0]  G_MAX     = 4'd5,
  parameter logic [3:0]  B_MAX     = 4'd5,
  parameter logic [18:0] MIN_COUNT = 19'd64,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480
) (
  input  logic        pixel_clock,
  input  logic        rst_i,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [11:0] pix_data,
  output logic        match_o,
  output logic        match_valid_o,
  output logic        result_valid,
  output logic        found,
  output logic [9:0]  x_min,
  output logic [9:0]  x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max,
  output logic [9:0]  x_center,
  output logic [9:0]  y_center,
  output logic [18:0] pix_count
);

  localparam int unsigned CW = 19;
  localparam int unsigned AW = 10;
  localparam logic [AW:0] H_LIM = (AW+1)'(H_ACTIVE);
  localparam logic [AW:0] V_LIM = (AW+1)'(V_ACTIVE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_LATCH = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Per-frame accumulators
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [AW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;

  // Published results and per-pixel flags
  logic          match_q, mvalid_q, rv_q, rv_d, found_q, found_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [AW-1:0] bxmin_q, bxmin_d, bxmax_q, bxmax_d;
  logic [AW-1:0] bymin_q, bymin_d, bymax_q, bymax_d;
  logic [AW-1:0] bxc_q, bxc_d, byc_q, byc_d;

  logic qual_c, match_c, acc_init_c;

  // Pixel qualification and colour window test
  assign qual_c  = pix_valid && ({1'b0, pix_x} < H_LIM) && ({1'b0, pix_y} < V_LIM);
  assign match_c = qual_c && (pix_data[11:8] >= R_MIN) &&
                   (pix_data[7:4] <= G_MAX) && (pix_data[3:0] <= B_MAX);

  // Next-state, accumulation and publish logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymin_d     = ymin_q;
    ymax_d     = ymax_q;
    rv_d       = 1'b0;
    found_d    = found_q;
    pcnt_d     = pcnt_q;
    bxmin_d    = bxmin_q;
    bxmax_d    = bxmax_q;
    bymin_d    = bymin_q;
    bymax_d    = bymax_q;
    bxc_d      = bxc_q;
    byc_d      = byc_q;
    acc_init_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d    = S_ACCUM;
          acc_init_c = 1'b1;
        end
      end
      S_ACCUM: begin
        if (frame_start) begin
          // Restart: discard the partial frame, nothing published
          acc_init_c = 1'b1;
        end else begin
          if (match_c) begin
            if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
            if (pix_x < xmin_q) xmin_d = pix_x;
            if (pix_x > xmax_q) xmax_d = pix_x;
            if (pix_y < ymin_q) ymin_d = pix_y;
            if (pix_y > ymax_q) ymax_d = pix_y;
          end
          if (frame_end) state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        rv_d    = 1'b1;
        pcnt_d  = cnt_q;
        if (cnt_q >= MIN_COUNT) begin
          found_d = 1'b1;
          bxmin_d = xmin_q;
          bxmax_d = xmax_q;
          bymin_d = ymin_q;
          bymax_d = ymax_q;
          bxc_d   = AW'(((AW+1)'(xmin_q) + (AW+1)'(xmax_q)) >> 1);
          byc_d   = AW'(((AW+1)'(ymin_q) + (AW+1)'(ymax_q)) >> 1);
        end else begin
          found_d = 1'b0;
          bxmin_d = '0;
          bxmax_d = '0;
          bymin_d = '0;
          bymax_d = '0;
          bxc_d   = '0;
          byc_d   = '0;
        end
        acc_init_c = 1'b1;
        state_d    = S_ACCUM;
      end
      default: state_d = S_IDLE;
    endcase

    if (acc_init_c) begin
      cnt_d  = '0;
      xmin_d = {AW{1'b1}};
      xmax_d = '0;
      ymin_d = {AW{1'b1}};
      ymax_d = '0;
    end
  end

  // State, accumulator and output registers
  always_ff @(posedge pixel_clock) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      xmin_q   <= {AW{1'b1}};
      xmax_q   <= '0;
      ymin_q   <= {AW{1'b1}};
      ymax_q   <= '0;
      match_q  <= 1'b0;
      mvalid_q <= 1'b0;
      rv_q     <= 1'b0;
      found_q  <= 1'b0;
      pcnt_q   <= '0;
      bxmin_q  <= '0;
      bxmax_q  <= '0;
      bymin_q  <= '0;
      bymax_q  <= '0;
      bxc_q    <= '0;
      byc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      ymin_q   <= ymin_d;
      ymax_q   <= ymax_d;
      match_q  <= match_c;
      mvalid_q <= qual_c;
      rv_q     <= rv_d;
      found_q  <= found_d;
      pcnt_q   <= pcnt_d;
      bxmin_q  <= bxmin_d;
      bxmax_q  <= bxmax_d;
      bymin_q  <= bymin_d;
      bymax_q  <= bymax_d;
      bxc_q    <= bxc_d;
      byc_q    <= byc_d;
    end
  end

  assign match_o       = match_q;
  assign match_valid_o = mvalid_q;
  assign result_valid  = rv_q;
  assign found         = found_q;
  assign pix_count     = pcnt_q;
  assign x_min         = bxmin_q;
  assign x_max         = bxmax_q;
  assign y_min         = bymin_q;
  assign y_max         = bymax_q;
  assign x_center      = bxc_q;
  assign y_center      = byc_q;

endmodule

// File: tb/tb_color_blob_tracker.sv
// Self-checking bench for color_blob_tracker: directed frames plus random
// traffic, compared every cycle against a queue-based frame model.
module tb_color_blob_tracker;

  logic        clk;
  logic        rst_i, frame_start, frame_end, pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_data;
  logic        match_o, match_valid_o, result_valid, found;
  logic [9:0]  x_min, x_max, y_min, y_max, x_center, y_center;
  logic [18:0] pix_count;

  color_blob_tracker dut (
    .pixel_clock  (clk),
    .rst_i        (rst_i),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_data     (pix_data),
    .match_o      (match_o),
    .match_valid_o(match_valid_o),
    .result_valid (result_valid),
    .found        (found),
    .x_min        (x_min),
    .x_max        (x_max),
    .y_min        (y_min),
    .y_max        (y_max),
    .x_center     (x_center),
    .y_center     (y_center),
    .pix_count    (pix_count)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: matching pixels of the open frame kept in queues;
  // the result set is derived from the queue contents when a frame closes.
  int qx[$];
  int qy[$];
  bit armed = 0, collecting = 0, latching = 0;
  int e_match = 0, e_mv = 0, e_rv = 0, e_found = 0, e_cnt = 0;
  int e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0, e_xc = 0, e_yc = 0;

  task automatic model_publish();
    int n, mnx, mxx, mny, mxy;
    n = qx.size();
    mnx = 1023; mxx = 0; mny = 1023; mxy = 0;
    foreach (qx[i]) begin
      if (qx[i] < mnx) mnx = qx[i];
      if (qx[i] > mxx) mxx = qx[i];
      if (qy[i] < mny) mny = qy[i];
      if (qy[i] > mxy) mxy = qy[i];
    end
    e_cnt = (n > 524287) ? 524287 : n;
    if (n >= 64) begin
      e_found = 1;
      e_xmin = mnx; e_xmax = mxx; e_ymin = mny; e_ymax = mxy;
      e_xc = (mnx + mxx) / 2;
      e_yc = (mny + mxy) / 2;
    end else begin
      e_found = 0;
      e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_xc = 0; e_yc = 0;
    end
  endtask

  always @(posedge clk) begin : model
    bit q, m;
    q = pix_valid && (pix_x < 10'd640) && (pix_y < 10'd480);
    m = q && (pix_data[11:8] >= 4'd10) && (pix_data[7:4] <= 4'd5) && (pix_data[3:0] <= 4'd5);
    e_rv = 0;
    if (rst_i) begin
      armed = 1; collecting = 0; latching = 0;
      qx.delete(); qy.delete();
      e_match = 0; e_mv = 0; e_found = 0; e_cnt = 0;
      e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_xc = 0; e_yc = 0;
    end else begin
      e_match = m ? 1 : 0;
      e_mv    = q ? 1 : 0;
      if (latching) begin
        model_publish();
        e_rv = 1;
        latching = 0;
        collecting = 1;
        qx.delete(); qy.delete();
      end else if (collecting) begin
        if (frame_start) begin
          qx.delete(); qy.delete();
        end else begin
          if (m) begin
            qx.push_back(int'(pix_x));
            qy.push_back(int'(pix_y));
          end
          if (frame_end) latching = 1;
        end
      end else if (frame_start) begin
        collecting = 1;
        qx.delete(); qy.delete();
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (armed) begin
      chk("match_o", 32'(match_o), e_match);
      chk("match_valid_o", 32'(match_valid_o), e_mv);
      chk("result_valid", 32'(result_valid), e_rv);
      chk("found", 32'(found), e_found);
      chk("pix_count", 32'(pix_count), e_cnt);
      chk("x_min", 32'(x_min), e_xmin);
      chk("x_max", 32'(x_max), e_xmax);
      chk("y_min", 32'(y_min), e_ymin);
      chk("y_max", 32'(y_max), e_ymax);
      chk("x_center", 32'(x_center), e_xc);
      chk("y_center", 32'(y_center), e_yc);
    end
  end

  // Drive one cycle of inputs on the falling edge
  task automatic cyc(input logic rs, input logic fs, input logic fe, input logic v,
                     input int x, input int y, input int d);
    @(negedge clk);
    rst_i       = rs;
    frame_start = fs;
    frame_end   = fe;
    pix_valid   = v;
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    pix_data    = 12'(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic px(input int x, input int y, input int d);
    cyc(0, 0, 0, 1, x, y, d);
  endtask

  task automatic pix_check(input int x, input int y, input int d, input int em, input int ev);
    px(x, y, d);
    @(posedge clk);
    #2;
    chk("lit_match_o", 32'(match_o), em);
    chk("lit_match_valid_o", 32'(match_valid_o), ev);
  endtask

  initial begin
    rst_i = 1'b1; frame_start = 1'b0; frame_end = 1'b0; pix_valid = 1'b0;
    pix_x = '0; pix_y = '0; pix_data = '0;

    // Reset state
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("rst_found", 32'(found), 0);
    chk("rst_pix_count", 32'(pix_count), 0);
    chk("rst_x_max", 32'(x_max), 0);
    chk("rst_match_valid_o", 32'(match_valid_o), 0);

    // Frame of black pixels, including out-of-range coordinates
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) px($urandom_range(0, 700), $urandom_range(0, 520), 12'h000);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(4);
    chk("blk_found", 32'(found), 0);
    chk("blk_pix_count", 32'(pix_count), 0);
    chk("blk_x_min", 32'(x_min), 0);

    // Red block 100..199 x 50..149 on green background
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int y = 40; y < 160; y++)
      for (int x = 90; x < 210; x++)
        px(x, y, (x >= 100 && x <= 199 && y >= 50 && y <= 149) ? 12'hF00 : 12'h0F0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(4);
    chk("blk2_pix_count", 32'(pix_count), 10000);
    chk("blk2_found", 32'(found), 1);
    chk("blk2_x_min", 32'(x_min), 100);
    chk("blk2_x_max", 32'(x_max), 199);
    chk("blk2_y_min", 32'(y_min), 50);
    chk("blk2_y_max", 32'(y_max), 149);
    chk("blk2_x_center", 32'(x_center), 149);
    chk("blk2_y_center", 32'(y_center), 99);

    // 63 matches: below threshold
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 63; i++) px(10 + i, 20, 12'hF00);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(4);
    chk("thr63_found", 32'(found), 0);
    chk("thr63_pix_count", 32'(pix_count), 63);
    chk("thr63_x_min", 32'(x_min), 0);

    // 64 matches: at threshold
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 64; i++) px(5 + i, 7, 12'hF00);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(4);
    chk("thr64_found", 32'(found), 1);
    chk("thr64_pix_count", 32'(pix_count), 64);
    chk("thr64_x_max", 32'(x_max), 68);
    chk("thr64_x_center", 32'(x_center), 36);
    chk("thr64_y_center", 32'(y_center), 7);

    // Colour window edges and active-area limits
    pix_check(1, 1, 12'hA55, 1, 1);
    pix_check(1, 1, 12'h955, 0, 1);
    pix_check(1, 1, 12'hA65, 0, 1);
    pix_check(1, 1, 12'hA56, 0, 1);
    pix_check(640, 5, 12'hF00, 0, 0);
    pix_check(5, 480, 12'hF00, 0, 0);
    pix_check(639, 479, 12'hF00, 1, 1);
    idle(2);

    // Matching pixel on the frame_end cycle; result two cycles later
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) px(570 + i, 400, 12'hF00);
    cyc(0, 0, 1, 1, 639, 479, 12'hF00);
    @(posedge clk); #2;
    chk("fe_rv_t1", 32'(result_valid), 0);
    idle(1);
    @(posedge clk); #2;
    chk("fe_rv_t2", 32'(result_valid), 1);
    chk("fe_pix_count", 32'(pix_count), 71);
    chk("fe_x_max", 32'(x_max), 639);
    chk("fe_y_max", 32'(y_max), 479);
    chk("fe_x_center", 32'(x_center), 604);
    chk("fe_y_center", 32'(y_center), 439);
    idle(1);
    @(posedge clk); #2;
    chk("fe_rv_t3", 32'(result_valid), 0);
    idle(2);

    // Reset mid-frame, stray frame_end, and restart by a second frame_start
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) px(i % 100, 10 + i / 100, 12'hF00);
    cyc(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("mrst_pix_count", 32'(pix_count), 0);
    chk("mrst_found", 32'(found), 0);
    chk("mrst_x_max", 32'(x_max), 0);
    idle(2);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(4);
    chk("stray_fe_pix_count", 32'(pix_count), 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) px(i, 1, 12'hF00);
    cyc(0, 1, 0, 1, 0, 2, 12'hF00);
    for (int i = 0; i < 70; i++) px(200 + i, 300, 12'hF00);
    cyc(0, 0, 1, 0, 0, 0, 0);
    idle(4);
    chk("restart_pix_count", 32'(pix_count), 70);
    chk("restart_x_min", 32'(x_min), 200);
    chk("restart_x_center", 32'(x_center), 234);

    // Random traffic
    for (int i = 0; i < 25000; i++) begin
      logic rs, fs, fe, v;
      int d;
      rs = ($urandom_range(0, 2999) == 0);
      fs = ($urandom_range(0, 399) == 0);
      fe = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        d = ($urandom_range(9, 15) << 8) | ($urandom_range(0, 6) << 4) | $urandom_range(0, 6);
      else
        d = $urandom_range(0, 4095);
      cyc(rs, fs, fe, v, $urandom_range(0, 660), $urandom_range(0, 500), d);
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/color_blob_tracker.md
Name: color_blob_tracker

Overview:
Classifies each 12-bit RGB444 pixel read from the VGA frame buffer against a target-colour threshold window. Accumulates per-frame statistics of matching pixels: count, bounding box and box centre. Sits downstream of the frame buffer, in parallel with the VGA sync stage, on the 25 MHz pixel clock. Publishes one result set per frame for overlay and LED/UART reporting logic.

Parameters:
R_MIN, 4'd10, matching pixel needs R >= R_MIN
G_MAX, 4'd5, matching pixel needs G <= G_MAX
B_MAX, 4'd5, matching pixel needs B <= B_MAX
MIN_COUNT, 19'd64, minimum matching pixels per frame to report found
H_ACTIVE, 640, active width; pixels with pix_x >= H_ACTIVE are ignored
V_ACTIVE, 480, active height; pixels with pix_y >= V_ACTIVE are ignored

Ports:
pixel_clock  in  1  25 MHz pixel clock; only clock
rst_i  in  1  synchronous reset, active-high
frame_start  in  1  one-cycle pulse before the first active pixel of a frame
frame_end  in  1  one-cycle pulse on or after the last active pixel of a frame
pix_valid  in  1  pix_x/pix_y/pix_data qualify this cycle
pix_x  in  10  pixel column
pix_y  in  10  pixel row
pix_data  in  12  {R[11:8],G[7:4],B[3:0]}
match_o  out  1  registered per-pixel match flag
match_valid_o  out  1  registered copy of qualified pix_valid
result_valid  out  1  one-cycle pulse when the result registers update
found  out  1  last frame count >= MIN_COUNT
x_min, x_max  out  10  bounding box columns
y_min, y_max  out  10  bounding box rows
x_center, y_center  out  10  (min+max)>>1 per axis
pix_count  out  19  matching pixels in last frame

Behaviour:
- Reset value of all outputs is 0. State goes to IDLE. Accumulators are set to initial values: cnt=0, xmin=ymin=10'h3FF, xmax=ymax=0.
- Qualification: q = pix_valid && pix_x < H_ACTIVE && pix_y < V_ACTIVE.
- Match: m = q && R >= R_MIN && G <= G_MAX && B <= B_MAX, using unsigned 4-bit compares.
- match_o is m registered; match_valid_o is q registered. Latency is 1 cycle in every state, IDLE included.
- FSM states:
  - IDLE: ignores accumulation and frame_end. frame_start -> ACCUM, with accumulators initialised.
  - ACCUM: when m, cnt += 1, and min/max are updated with pix_x/pix_y. A pixel on the frame_start cycle is not accumulated. frame_start again restarts the frame: accumulators are re-initialised and results are not published. frame_end -> LATCH. A matching pixel on the frame_end cycle IS counted before the latch.
  - LATCH: lasts one cycle. Copies the accumulators to the outputs, pulses result_valid, re-initialises the accumulators, then goes to ACCUM. A pixel during LATCH is ignored. frame_start during LATCH goes to ACCUM, with accumulators already initialised.
- Publish rule when cnt >= MIN_COUNT: found=1, outputs = accumulators, centres = ({1'b0,min}+max)>>1, computed 11-bit then truncated to 10.
- Publish rule when cnt < MIN_COUNT: found=0, pix_count=cnt, all box and centre outputs = 0.
- cnt saturates at 19'h7FFFF; it never wraps.
- Outputs hold between result_valid pulses.
- result_valid is high exactly one cycle, 2 cycles after the frame_end cycle (frame_end at T, LATCH at T+1, outputs visible at T+2).
- rst_i mid-frame: everything returns to reset values next cycle. No result is published for the partial frame.
- frame_start and frame_end asserted in the same cycle: frame_start wins (restart, no publish).

Test Plan:
1. Reset, then drive 640x480 frame all pix_data=12'h000 -> match_o never 1; result_valid once; found=0; pix_count=0; box=0.
2. Frame with 12'hF00 block x=100..199, y=50..149, background 12'h0F0 -> pix_count=10000, found=1, x_min=100, x_max=199, y_min=50, y_max=149, x_center=149, y_center=99.
3. Frame with 63 red pixels -> found=0, pix_count=63, box=0. Next frame with 64 red pixels at (5,7) row -> found=1, pix_count=64.
4. Boundary pixels 12'hA55 (match) and 12'h955, 12'hA65, 12'hA56 (no match) -> match_o=1 only for 12'hA55, 1 cycle after pix_valid. Pixel at pix_x=640 with 12'hF00 -> match_o=0, match_valid_o=0, not counted.
5. Red pixel at (639,479) on frame_end cycle -> counted; x_max=639, y_max=479; result_valid exactly 2 cycles after frame_end.
6. Assert rst_i after 1000 red pixels mid-frame -> outputs 0, no result_valid. frame_end before the next frame_start is ignored. Second frame_start mid-frame discards prior pixels.
